adc_avg_decim: RTL and testbench
================================

ADC_AVG_DECIM -- requirements
Module: adc_avg_decim

Interface
REQ-001 SHALL have parameter DW, default 24, meaning sample width in bits (two's complement).
REQ-002 SHALL have parameter LOG2_MAX, default 4, meaning the largest averaging exponent (max 16 samples).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of output result entries.
REQ-004 SHALL have clk  in  1  system clock; one clock, all logic on rising edge.
REQ-005 SHALL have rst_l  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have data_i  in  DW  sample word from the ADC interface controller.
REQ-007 SHALL have channel_i  in  1  channel tag of data_i: 0 = ch1, 1 = ch2.
REQ-008 SHALL have rd_en_i  in  1  single-cycle sample strobe; data_i/channel_i valid only when high.
REQ-009 SHALL have avg_log2  in  3  averaging exponent n; N = 2^n samples per result.
REQ-010 SHALL have clear  in  1  synchronous flush/reconfigure pulse.
REQ-011 SHALL have data_o  out  DW  averaged result.
REQ-012 SHALL have ch_o  out  1  channel tag of data_o.
REQ-013 SHALL have valid_o  out  1  result available at FIFO head.
REQ-014 SHALL have ready_i  in  1  consumer accepts head when valid_o && ready_i.
REQ-015 SHALL have overflow_o  out  1  sticky: a result was dropped.

Function
REQ-016 SHALL keep an independent accumulator (DW+LOG2_MAX bits, signed) and sample counter (LOG2_MAX+1 bits) per channel.
REQ-017 SHALL latch n = min(avg_log2, LOG2_MAX) on reset release and on every clear; avg_log2 changes at other times SHALL have no effect.
REQ-018 On rd_en_i, SHALL add sign-extended data_i to acc[channel_i] and increment cnt[channel_i]; the other channel SHALL be untouched.
REQ-019 When the accepted sample is the Nth for its channel, SHALL form result = (acc + sample) arithmetic-shifted right by n (truncation toward minus infinity), truncated to DW bits, and zero that channel's acc/cnt in the same cycle.
REQ-020 n = 0 SHALL pass every sample through unchanged.
REQ-021 Result SHALL be registered in a stage-1 register in the cycle after rd_en_i and pushed into the FIFO in the following cycle; valid_o SHALL rise 2 cycles after the rd_en_i cycle when the FIFO was empty.
REQ-022 Back-to-back rd_en_i on alternating channels SHALL be sustained every cycle with no loss while the FIFO has space.
REQ-023 FIFO SHALL pop on valid_o && ready_i; simultaneous push and pop when full SHALL succeed (no drop).
REQ-024 Push while full without pop SHALL drop the new result, keep FIFO contents, and set overflow_o.
REQ-025 data_o/ch_o SHALL hold stable while valid_o && !ready_i.
REQ-026 clear SHALL zero both accumulators, counters, stage-1 register, FIFO, and overflow_o; valid_o SHALL be 0 the next cycle; rd_en_i coincident with clear SHALL be discarded.

Reset
REQ-027 On rst_l low: data_o = 0, ch_o = 0, valid_o = 0, overflow_o = 0; accumulators, counters, FIFO pointers and stage-1 valid = 0; n = 0.
REQ-028 Reset asserted mid-accumulation SHALL discard all partial sums; first result after release SHALL use only post-reset samples.

Structure
REQ-029 DW, LOG2_MAX, FIFO_DEPTH defaults and the result-entry layout {ch, data} SHALL live in shared package adc_pkg.
REQ-030 FIFO SHALL be a separate sub-module adc_res_fifo (synchronous, same clk/rst_l, full/empty flags, push/pop).

Verification
REQ-031 n=2, ch1 samples 4, 8, 12, 16 -> one result data_o=10, ch_o=0, valid_o 2 cycles after the 4th rd_en_i.
REQ-032 n=1, ch2 samples -3, -4 -> data_o = -4 (0xFFFFFC), ch_o=1; n=0 -> every sample passes unchanged.
REQ-033 n=1, interleaved ch1 100, ch2 -100, ch1 200, ch2 -200 on consecutive cycles -> results 150 (ch 0) then -150 (ch 1), in that order.
REQ-034 n=0, ready_i=0, 5 samples -> 4 results held, overflow_o=1, first result unchanged; then ready_i=1 drains exactly 4 in order.
REQ-035 n=3, 5 ch1 samples then clear with avg_log2=1, then 2 samples of 6 -> single result 6; overflow_o and FIFO empty after clear.
REQ-036 rst_l pulsed low after 3 of 4 samples (n=2), then 4 samples of 7 -> single result 7; all outputs 0 during reset.

Source files
------------

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared defaults and result-entry layout for the ADC averaging decimator
package adc_pkg;

    localparam int ADC_DW         = 24;
    localparam int ADC_LOG2_MAX   = 4;
    localparam int ADC_FIFO_DEPTH = 4;

    // FIFO entry layout: channel tag above the averaged sample
    typedef struct packed {
        logic              ch;
        logic [ADC_DW-1:0] data;
    } adc_res_t;

endpackage

// File: rtl/adc_res_fifo.sv
// rtl/adc_res_fifo.sv - synchronous result FIFO with flush; push while full succeeds only alongside a pop
module adc_res_fifo #(
    parameter int W     = 25,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        full    = (count_q == CNTW'(DEPTH));
        empty   = (count_q == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= bump(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= bump(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CNTW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNTW'(1);
        end
    end

    // Storage needs no reset: entries are only visible behind a valid count
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/adc_avg_decim.sv
// rtl/adc_avg_decim.sv - two-channel power-of-two averaging decimator with result FIFO
module adc_avg_decim
    import adc_pkg::*;
#(
    parameter int DW         = ADC_DW,
    parameter int LOG2_MAX   = ADC_LOG2_MAX,
    parameter int FIFO_DEPTH = ADC_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic [DW-1:0] data_i,
    input  logic          channel_i,
    input  logic          rd_en_i,
    input  logic [2:0]    avg_log2,
    input  logic          clear,
    output logic [DW-1:0] data_o,
    output logic          ch_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          overflow_o
);

    localparam int AW = DW + LOG2_MAX;
    localparam int CW = LOG2_MAX + 1;

    logic signed [AW-1:0] acc_q [2];
    logic [CW-1:0]        cnt_q [2];
    logic [2:0]           n_q;
    logic                 cfg_load_q;
    logic                 s1_valid_q;
    logic                 s1_ch_q;
    logic [DW-1:0]        s1_data_q;
    logic                 overflow_q;

    logic [2:0]           n_req;
    logic [2:0]           n_eff;
    logic signed [AW-1:0] sample_ext;
    logic signed [AW-1:0] sum;
    logic [DW-1:0]        avg;
    logic [CW-1:0]        cnt_next;
    logic                 last;

    logic [DW:0]          fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;

    // cfg_load_q marks the first cycle after reset release, where n comes straight from avg_log2
    always_comb begin
        n_req      = (int'(avg_log2) > LOG2_MAX) ? 3'(LOG2_MAX) : avg_log2;
        n_eff      = cfg_load_q ? n_req : n_q;
        sample_ext = {{LOG2_MAX{data_i[DW-1]}}, data_i};
        sum        = acc_q[channel_i] + sample_ext;
        cnt_next   = cnt_q[channel_i] + CW'(1);
        last       = (cnt_next == (CW'(1) << n_eff));
        avg        = DW'(sum >>> n_eff);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            acc_q[0]   <= '0;
            acc_q[1]   <= '0;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            n_q        <= '0;
            cfg_load_q <= 1'b1;
            s1_valid_q <= 1'b0;
            s1_ch_q    <= 1'b0;
            s1_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            cfg_load_q <= 1'b0;
            if (clear || cfg_load_q) n_q <= n_req;
            if (clear) begin
                acc_q[0]   <= '0;
                acc_q[1]   <= '0;
                cnt_q[0]   <= '0;
                cnt_q[1]   <= '0;
                s1_valid_q <= 1'b0;
                s1_ch_q    <= 1'b0;
                s1_data_q  <= '0;
                overflow_q <= 1'b0;
            end else begin
                s1_valid_q <= 1'b0;
                if (rd_en_i) begin
                    if (last) begin
                        acc_q[channel_i] <= '0;
                        cnt_q[channel_i] <= '0;
                        s1_valid_q       <= 1'b1;
                        s1_ch_q          <= channel_i;
                        s1_data_q        <= avg;
                    end else begin
                        acc_q[channel_i] <= sum;
                        cnt_q[channel_i] <= cnt_next;
                    end
                end
                if (s1_valid_q && fifo_full && !fifo_pop) overflow_q <= 1'b1;
            end
        end
    end

    adc_res_fifo #(
        .W     (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_l     (rst_l),
        .flush     (clear),
        .push      (s1_valid_q),
        .push_data ({s1_ch_q, s1_data_q}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign valid_o    = !fifo_empty;
    assign fifo_pop   = valid_o && ready_i;
    assign data_o     = valid_o ? fifo_head[DW-1:0] : '0;
    assign ch_o       = valid_o ? fifo_head[DW] : 1'b0;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_adc_avg_decim.sv
// tb/tb_adc_avg_decim.sv - self-checking bench: vector table, corner sequences, randomized model compare
module tb_adc_avg_decim;
    import adc_pkg::*;

    localparam int DW = ADC_DW;

    logic          clk = 1'b0;
    logic          rst_l;
    logic [DW-1:0] data_i;
    logic          channel_i;
    logic          rd_en_i;
    logic [2:0]    avg_log2;
    logic          clear;
    logic [DW-1:0] data_o;
    logic          ch_o;
    logic          valid_o;
    logic          ready_i;
    logic          overflow_o;

    int checks   = 0;
    int failures = 0;

    adc_avg_decim dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .data_i     (data_i),
        .channel_i  (channel_i),
        .rd_en_i    (rd_en_i),
        .avg_log2   (avg_log2),
        .clear      (clear),
        .data_o     (data_o),
        .ch_o       (ch_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       n;
        logic             ch;
        int               cnt;
        logic [3:0][31:0] smp;
        int               exp;
    } vec_t;

    vec_t        vecs [7];
    adc_res_t    got [$];
    adc_res_t    expq [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic adc_res_t ent(input logic ch, input int v);
        logic [31:0] t;
        t = v;
        return {ch, t[DW-1:0]};
    endfunction

    function automatic vec_t mk(input int n, input logic ch, input int cnt,
                                input int s0, input int s1, input int s2, input int s3, input int exp);
        vec_t v;
        v.n   = 3'(n);
        v.ch  = ch;
        v.cnt = cnt;
        v.smp = {32'(s3), 32'(s2), 32'(s1), 32'(s0)};
        v.exp = exp;
        return v;
    endfunction

    // floor(sum / 2^n), wrapped to the output width
    function automatic logic [DW-1:0] favg(input longint s, input int n);
        longint d;
        longint q;
        d = longint'(1) << n;
        q = s / d;
        if ((s % d) != 0 && s < 0) q = q - 1;
        return q[DW-1:0];
    endfunction

    task automatic apply_clear(input int a);
        avg_log2 = 3'(a);
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
    endtask

    // leaves rd_en_i high so callers can issue back-to-back samples
    task automatic drive(input logic ch, input int v);
        logic [31:0] t;
        t         = v;
        data_i    = t[DW-1:0];
        channel_i = ch;
        rd_en_i   = 1'b1;
        tick();
    endtask

    task automatic collect(input int cycles);
        got.delete();
        ready_i = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (valid_o) got.push_back({ch_o, data_o});
            tick();
        end
        ready_i = 1'b0;
    endtask

    task automatic chk_got(input string nm, input int idx, input adc_res_t exp);
        adc_res_t a;
        a = (idx < got.size()) ? got[idx] : {(DW+1){1'bx}};
        chk(nm, a, exp);
    endtask

    initial begin
        logic [31:0]          e32;
        logic [31:0]          r;
        logic signed [DW-1:0] ds;
        longint               sums [2];
        int                   cnts [2];
        int                   nm;
        int                   a;
        adc_res_t             e;

        rst_l = 1'b1; data_i = '0; channel_i = 1'b0; rd_en_i = 1'b0;
        avg_log2 = 3'd0; clear = 1'b0; ready_i = 1'b0;
        #1 rst_l = 1'b0;
        repeat (2) tick();
        chk("rst_data", data_o, 0);
        chk("rst_ch", ch_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ovf", overflow_o, 0);
        rst_l = 1'b1;
        tick();

        vecs[0] = mk(2, 1'b0, 4, 4, 8, 12, 16, 10);
        vecs[1] = mk(1, 1'b1, 2, -3, -4, 0, 0, -4);
        vecs[2] = mk(0, 1'b0, 1, 5, 0, 0, 0, 5);
        vecs[3] = mk(0, 1'b1, 1, -8388608, 0, 0, 0, -8388608);
        vecs[4] = mk(2, 1'b1, 4, -1, -1, -1, -2, -2);
        vecs[5] = mk(1, 1'b0, 2, 8388607, 8388607, 0, 0, 8388607);
        vecs[6] = mk(1, 1'b1, 2, -8388608, -8388607, 0, 0, -8388608);

        for (int i = 0; i < 7; i++) begin
            apply_clear(int'(vecs[i].n));
            for (int j = 0; j < vecs[i].cnt; j++) drive(vecs[i].ch, int'(vecs[i].smp[j]));
            rd_en_i = 1'b0;
            chk("vec_early", valid_o, 0);
            tick();
            e32 = vecs[i].exp;
            chk("vec_valid", valid_o, 1);
            chk("vec_data", data_o, e32[DW-1:0]);
            chk("vec_ch", ch_o, vecs[i].ch);
            ready_i = 1'b1;
            tick();
            ready_i = 1'b0;
            chk("vec_pop", valid_o, 0);
        end

        // interleaved channels on consecutive cycles
        apply_clear(1);
        drive(1'b0, 100); drive(1'b1, -100); drive(1'b0, 200); drive(1'b1, -200);
        rd_en_i = 1'b0;
        collect(8);
        chk("ilv_count", got.size(), 2);
        chk_got("ilv_first", 0, ent(1'b0, 150));
        chk_got("ilv_second", 1, ent(1'b1, -150));

        // overflow: five pass-through results into a four-entry FIFO with no consumer
        apply_clear(0);
        for (int j = 0; j < 5; j++) drive(1'b0, 11 + j);
        rd_en_i = 1'b0;
        tick();
        chk("ovf_set", overflow_o, 1);
        chk("ovf_head", data_o, 11);
        tick();
        chk("ovf_hold", data_o, 11);
        collect(10);
        chk("ovf_count", got.size(), 4);
        for (int j = 0; j < 4; j++) chk_got("ovf_order", j, ent(1'b0, 11 + j));
        chk("ovf_sticky", overflow_o, 1);
        drive(1'b0, 1); drive(1'b0, 2);
        rd_en_i = 1'b0;
        repeat (2) tick();
        chk("pre_clr_valid", valid_o, 1);

        // clear flushes, and avg_log2 only takes effect at a clear
        apply_clear(3);
        chk("clr_ovf", overflow_o, 0);
        chk("clr_valid", valid_o, 0);
        avg_log2 = 3'd0;
        for (int j = 0; j < 5; j++) drive(1'b0, 9);
        rd_en_i = 1'b0;
        repeat (2) tick();
        chk("no_relatch", valid_o, 0);
        avg_log2 = 3'd1; clear = 1'b1;
        data_i = 24'd100; channel_i = 1'b0; rd_en_i = 1'b1;
        tick();
        clear = 1'b0; rd_en_i = 1'b0;
        chk("clr2_valid", valid_o, 0);
        drive(1'b0, 6); drive(1'b0, 6);
        rd_en_i = 1'b0;
        collect(6);
        chk("clr_count", got.size(), 1);
        chk_got("clr_result", 0, ent(1'b0, 6));

        // reset mid-accumulation with a result pending
        apply_clear(2);
        for (int j = 0; j < 4; j++) drive(1'b1, 20);
        for (int j = 0; j < 3; j++) drive(1'b0, 100);
        rd_en_i = 1'b0;
        chk("prerst_valid", valid_o, 1);
        rst_l = 1'b0;
        tick();
        chk("inrst_data", data_o, 0);
        chk("inrst_ch", ch_o, 0);
        chk("inrst_valid", valid_o, 0);
        chk("inrst_ovf", overflow_o, 0);
        rst_l = 1'b1;
        tick();
        for (int j = 0; j < 4; j++) drive(1'b0, 7);
        rd_en_i = 1'b0;
        collect(6);
        chk("rst_count", got.size(), 1);
        chk_got("rst_result", 0, ent(1'b0, 7));

        // randomized traffic against the arithmetic model
        for (int round = 0; round < 3; round++) begin
            a = 2 + int'($urandom_range(0, 5));
            nm = (a > ADC_LOG2_MAX) ? ADC_LOG2_MAX : a;
            apply_clear(a);
            sums[0] = 0; sums[1] = 0; cnts[0] = 0; cnts[1] = 0;
            expq.delete();
            for (int c = 0; c < 500; c++) begin
                ready_i = (c % 2 == 0) || ($urandom_range(0, 1) == 1);
                if (valid_o && ready_i) begin
                    if (expq.size() == 0) begin
                        chk("rnd_spurious", expq.size(), 1);
                    end else begin
                        e = expq.pop_front();
                        chk("rnd_data", data_o, e.data);
                        chk("rnd_ch", ch_o, e.ch);
                    end
                end
                rd_en_i = (c < 460) && ($urandom_range(0, 1) == 1);
                if (rd_en_i) begin
                    r = $urandom;
                    data_i = r[DW-1:0];
                    channel_i = 1'($urandom_range(0, 1));
                    ds = data_i;
                    sums[channel_i] += ds;
                    cnts[channel_i]++;
                    if (cnts[channel_i] == (1 << nm)) begin
                        expq.push_back({channel_i, favg(sums[channel_i], nm)});
                        sums[channel_i] = 0;
                        cnts[channel_i] = 0;
                    end
                end
                tick();
            end
            rd_en_i = 1'b0;
            ready_i = 1'b0;
            chk("rnd_left", expq.size(), 0);
            chk("rnd_ovf", overflow_o, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
